// File: rtl/uart_io_pkg.sv
// Shared definitions for the UART I/O bridge: register word addresses,
// STATUS bit positions and the default baud divider.
package uart_io_pkg;

  localparam logic [13:0] UIO_TXDATA = 14'h3F00;
  localparam logic [13:0] UIO_STATUS = 14'h3F01;
  localparam logic [13:0] UIO_RXDATA = 14'h3F02;
  localparam logic [13:0] UIO_CTRL   = 14'h3F03;

  localparam int ST_TX_EMPTY = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_RX_NEMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_OVF   = 5;

  localparam int CTRL_RX_EN   = 16;
  localparam int CTRL_NO_ECHO = 17;

  // 100 MHz system clock divided down to 115200 baud
  localparam logic [15:0] UIO_TERM_RST = 16'd868;

endpackage

// File: rtl/uart_io_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module uart_io_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_io_bridge.sv
// Memory-mapped UART peripheral: TX FIFO drained into the monitor under
// back-pressure, RX FIFO polled by the CPU, plus baud/echo control.
module uart_io_bridge
  import uart_io_pkg::*;
#(
  parameter int          TX_DEPTH = 4,
  parameter int          RX_DEPTH = 8,
  parameter logic [15:0] TERM_RST = UIO_TERM_RST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_we,
  input  logic [15:2] io_wadr,
  input  logic [31:0] io_wdata,
  input  logic        io_radr_en,
  input  logic [15:2] io_radr,
  output logic [31:0] io_rdata,
  output logic [7:0]  uart_io_char,
  output logic        uart_io_we,
  input  logic        uart_io_full,
  input  logic [7:0]  rout,
  input  logic        rout_en,
  output logic [15:0] uart_term,
  output logic        rx_disable_echoback
);

  logic       wr_txdata, wr_status, wr_ctrl, rd_rxdata;
  logic       tx_full, tx_empty, tx_pop, tx_ovf, tx_ovf_set;
  logic       rx_full, rx_empty, rx_push, rx_pop, rx_ovf, rx_ovf_set;
  logic       rx_en;
  logic [7:0] tx_head, rx_head;
  logic [5:0] status_bits;
  logic [31:0] rd_mux;
  logic       unused_wdata;

  assign unused_wdata = ^io_wdata[31:18];

  assign wr_txdata = io_we && (io_wadr == UIO_TXDATA);
  assign wr_status = io_we && (io_wadr == UIO_STATUS);
  assign wr_ctrl   = io_we && (io_wadr == UIO_CTRL);
  assign rd_rxdata = io_radr_en && (io_radr == UIO_RXDATA);

  // Drain is combinational so back-pressure is honoured in the same cycle
  assign tx_pop       = !tx_empty && !uart_io_full;
  assign uart_io_we   = tx_pop;
  assign uart_io_char = tx_pop ? tx_head : 8'h00;
  assign tx_ovf_set   = wr_txdata && tx_full && !tx_pop;

  assign rx_push    = rout_en && rx_en;
  assign rx_pop     = rd_rxdata && !rx_empty;
  assign rx_ovf_set = rx_push && rx_full && !rx_pop;

  uart_io_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_txdata),
    .pop   (tx_pop),
    .wdata (io_wdata[7:0]),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  uart_io_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (rout),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_term           <= TERM_RST;
      rx_en               <= 1'b0;
      rx_disable_echoback <= 1'b0;
    end else if (wr_ctrl) begin
      uart_term           <= io_wdata[15:0];
      rx_en               <= io_wdata[CTRL_RX_EN];
      rx_disable_echoback <= io_wdata[CTRL_NO_ECHO];
    end
  end

  // Sticky overflow flags; a hardware set wins over a W1C in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
    end else begin
      tx_ovf <= tx_ovf_set || (tx_ovf && !(wr_status && io_wdata[ST_TX_OVF]));
      rx_ovf <= rx_ovf_set || (rx_ovf && !(wr_status && io_wdata[ST_RX_OVF]));
    end
  end

  always_comb begin
    status_bits               = '0;
    status_bits[ST_TX_EMPTY]  = tx_empty;
    status_bits[ST_TX_FULL]   = tx_full;
    status_bits[ST_RX_NEMPTY] = !rx_empty;
    status_bits[ST_RX_FULL]   = rx_full;
    status_bits[ST_TX_OVF]    = tx_ovf;
    status_bits[ST_RX_OVF]    = rx_ovf;
  end

  always_comb begin
    rd_mux = '0;
    case (io_radr)
      UIO_STATUS: rd_mux = {26'b0, status_bits};
      UIO_RXDATA: rd_mux = rx_empty ? 32'h0 : {23'b0, 1'b1, rx_head};
      UIO_CTRL:   rd_mux = {14'b0, rx_disable_echoback, rx_en, uart_term};
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_rdata <= '0;
    end else if (io_radr_en) begin
      io_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_uart_io_bridge.sv
// Directed self-checking bench for uart_io_bridge: reset state, TX drain and
// back-pressure, RX capture/overflow, same-cycle push/pop and async reset.
module tb_uart_io_bridge;
  import uart_io_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        io_we;
  logic [15:2] io_wadr;
  logic [31:0] io_wdata;
  logic        io_radr_en;
  logic [15:2] io_radr;
  logic [31:0] io_rdata;
  logic [7:0]  uart_io_char;
  logic        uart_io_we;
  logic        uart_io_full;
  logic [7:0]  rout;
  logic        rout_en;
  logic [15:0] uart_term;
  logic        rx_disable_echoback;

  int assertion_count = 0;
  int fail_count = 0;
  int cycle_cnt = 0;
  int we_while_full = 0;
  logic [7:0] tx_seen[$];
  int tx_cycle[$];

  uart_io_bridge #(.TX_DEPTH(4), .RX_DEPTH(8), .TERM_RST(16'd868)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .io_we               (io_we),
    .io_wadr             (io_wadr),
    .io_wdata            (io_wdata),
    .io_radr_en          (io_radr_en),
    .io_radr             (io_radr),
    .io_rdata            (io_rdata),
    .uart_io_char        (uart_io_char),
    .uart_io_we          (uart_io_we),
    .uart_io_full        (uart_io_full),
    .rout                (rout),
    .rout_en             (rout_en),
    .uart_term           (uart_term),
    .rx_disable_echoback (rx_disable_echoback)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on negedge; the TX port is observed 1ns before each posedge
  always begin
    @(negedge clk);
    #4;
    cycle_cnt++;
    if (uart_io_we) begin
      tx_seen.push_back(uart_io_char);
      tx_cycle.push_back(cycle_cnt);
      if (uart_io_full) we_while_full++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertion_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // One bus cycle: drive at negedge, hold through the next posedge
  task automatic applyStimulus(input logic we, input logic [15:2] wadr, input logic [31:0] wdata,
                               input logic ren, input logic [15:2] radr);
    io_we      = we;
    io_wadr    = wadr;
    io_wdata   = wdata;
    io_radr_en = ren;
    io_radr    = radr;
    @(negedge clk);
    io_we      = 1'b0;
    io_radr_en = 1'b0;
  endtask

  task automatic ioWrite(input logic [15:2] adr, input logic [31:0] data);
    applyStimulus(1'b1, adr, data, 1'b0, '0);
  endtask

  task automatic ioRead(input logic [15:2] adr, output logic [31:0] data);
    applyStimulus(1'b0, '0, '0, 1'b1, adr);
    data = io_rdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rxInject(input logic [7:0] ch);
    rout    = ch;
    rout_en = 1'b1;
    @(negedge clk);
    rout_en = 1'b0;
  endtask

  logic [31:0] rd;

  initial begin
    rst_n = 1'b0; io_we = 1'b0; io_wadr = '0; io_wdata = '0;
    io_radr_en = 1'b0; io_radr = '0; uart_io_full = 1'b0;
    rout = '0; rout_en = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);

    // Reset state
    checkOutput("rst_term", {16'h0, uart_term}, 32'd868);
    checkOutput("rst_we", {31'h0, uart_io_we}, 32'h0);
    checkOutput("rst_char", {24'h0, uart_io_char}, 32'h0);
    checkOutput("rst_noecho", {31'h0, rx_disable_echoback}, 32'h0);
    checkOutput("rst_rdata", io_rdata, 32'h0);
    ioRead(UIO_CTRL, rd);
    checkOutput("rst_ctrl", rd, 32'h0000_0364);
    ioRead(UIO_STATUS, rd);
    checkOutput("rst_status", rd, 32'h0000_0001);

    // Back-to-back TX writes stream out on consecutive cycles
    tx_seen.delete(); tx_cycle.delete();
    ioWrite(UIO_TXDATA, 32'h41);
    ioWrite(UIO_TXDATA, 32'h42);
    ioWrite(UIO_TXDATA, 32'h43);
    idle(4);
    checkOutput("tx3_count", tx_seen.size(), 32'd3);
    if (tx_seen.size() == 3) begin
      checkOutput("tx3_c0", {24'h0, tx_seen[0]}, 32'h41);
      checkOutput("tx3_c1", {24'h0, tx_seen[1]}, 32'h42);
      checkOutput("tx3_c2", {24'h0, tx_seen[2]}, 32'h43);
      checkOutput("tx3_consec", tx_cycle[2] - tx_cycle[0], 32'd2);
    end

    // Back-pressure: 4 queued, 5th dropped with tx_ovf
    tx_seen.delete(); tx_cycle.delete();
    uart_io_full = 1'b1;
    for (int i = 0; i < 5; i++) ioWrite(UIO_TXDATA, 32'h50 + i);
    ioRead(UIO_STATUS, rd);
    checkOutput("bp_status", rd, 32'h0000_0012);
    checkOutput("bp_none_sent", tx_seen.size(), 32'd0);
    uart_io_full = 1'b0;
    idle(8);
    checkOutput("bp_we_while_full", we_while_full, 32'd0);
    checkOutput("bp_count", tx_seen.size(), 32'd4);
    if (tx_seen.size() == 4)
      for (int i = 0; i < 4; i++) checkOutput($sformatf("bp_c%0d", i), {24'h0, tx_seen[i]}, 32'h50 + i);
    ioWrite(UIO_STATUS, 32'h10);
    ioRead(UIO_STATUS, rd);
    checkOutput("bp_w1c", rd, 32'h0000_0001);

    // CTRL fields and RX ignored while rx_en=0
    ioWrite(UIO_CTRL, 32'h0003_0123);
    checkOutput("ctrl_term", {16'h0, uart_term}, 32'h0123);
    checkOutput("ctrl_noecho", {31'h0, rx_disable_echoback}, 32'h1);
    ioRead(UIO_CTRL, rd);
    checkOutput("ctrl_read", rd, 32'h0003_0123);
    ioWrite(UIO_CTRL, 32'h0000_0364);
    rxInject(8'h99);
    ioRead(UIO_STATUS, rd);
    checkOutput("rx_dis_status", rd, 32'h0000_0001);

    // RX fill past capacity
    ioWrite(UIO_CTRL, 32'h0001_0364);
    for (int i = 0; i < 9; i++) rxInject(8'h30 + i);
    ioRead(UIO_STATUS, rd);
    checkOutput("rx_ovf_status", rd, 32'h0000_002D);
    for (int i = 0; i < 8; i++) begin
      ioRead(UIO_RXDATA, rd);
      checkOutput($sformatf("rx_rd%0d", i), rd, 32'h130 + i);
    end
    ioRead(UIO_RXDATA, rd);
    checkOutput("rx_rd_empty", rd, 32'h0);
    ioWrite(UIO_STATUS, 32'h20);

    // Same-cycle push on full FIFO and pop: no overflow, count stays 8
    for (int i = 0; i < 8; i++) rxInject(8'h60 + i);
    ioRead(UIO_STATUS, rd);
    checkOutput("sim_full_status", rd, 32'h0000_000D);
    rout    = 8'h68;
    rout_en = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b1, UIO_RXDATA);
    rout_en = 1'b0;
    checkOutput("sim_pop_data", io_rdata, 32'h160);
    ioRead(UIO_STATUS, rd);
    checkOutput("sim_status", rd, 32'h0000_000D);
    for (int i = 1; i <= 8; i++) begin
      ioRead(UIO_RXDATA, rd);
      checkOutput($sformatf("sim_rd%0d", i), rd, 32'h160 + i);
    end
    ioRead(UIO_RXDATA, rd);
    checkOutput("sim_rd_empty", rd, 32'h0);

    // Async reset while TX is queued and being issued
    uart_io_full = 1'b1;
    ioWrite(UIO_TXDATA, 32'h70);
    ioWrite(UIO_TXDATA, 32'h71);
    ioWrite(UIO_TXDATA, 32'h72);
    ioRead(UIO_CTRL, rd);
    checkOutput("pre_rst_ctrl", rd, 32'h0001_0364);
    uart_io_full = 1'b0;
    #1;
    checkOutput("pre_rst_we", {31'h0, uart_io_we}, 32'h1);
    checkOutput("pre_rst_char", {24'h0, uart_io_char}, 32'h70);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_we", {31'h0, uart_io_we}, 32'h0);
    checkOutput("async_char", {24'h0, uart_io_char}, 32'h0);
    checkOutput("async_rdata", io_rdata, 32'h0);
    idle(2);
    rst_n = 1'b1;
    tx_seen.delete(); tx_cycle.delete();
    idle(6);
    checkOutput("post_rst_sent", tx_seen.size(), 32'd0);
    ioRead(UIO_STATUS, rd);
    checkOutput("post_rst_status", rd, 32'h0000_0001);
    ioRead(UIO_CTRL, rd);
    checkOutput("post_rst_ctrl", rd, 32'h0000_0364);

    $display("End of test - %0d assertions evaluated, %0d failures", assertion_count, fail_count);
    $finish;
  end

endmodule
